fix_query_sched: RTL
====================

# fix_query_sched

Sequencer and arbiter that shares the single tag-lookup path (message-location table, tag CAM, value RAM) among NUM_REQ host query requesters. Each query names a stored message and a FIX tag. The block performs the steps in order: location read, CAM search over that message's address window, and value RAM read. It returns hit/miss and the 256-bit value. It sits between host-side query ports and the parser's storage blocks, replacing direct host drive of the lookup strobes.

## Interface
- NUM_REQ, 4, number of query requesters
- NUM_MESSAGE, 10, messages held in location table
- MSG_WIDTH, 4, message-number width (≥ clog2(NUM_MESSAGE))
- TAG_WIDTH, 32, tag width
- ADDR_WIDTH, 5, CAM/value RAM address width
- VALUE_WIDTH, 256, value width
- SEARCH_LAT, 2, cycles from search strobe to valid tag_match_i/index_i (≥1)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_i  in  NUM_REQ  per-requester query request, held until ack
- req_msg_i  in  NUM_REQ*MSG_WIDTH  message number per requester
- req_tag_i  in  NUM_REQ*TAG_WIDTH  tag per requester
- ack_o  out  NUM_REQ  one-hot, one-cycle completion pulse
- hit_o  out  1  result valid-hit, qualified by any ack_o
- value_o  out  VALUE_WIDTH  result value, qualified by ack_o; 0 on miss
- busy_o  out  1  query in progress
- wr_busy_i  in  1  message being written to storage; no new grant while high
- loc_re_o  out  1  location-table read strobe
- loc_msg_o  out  MSG_WIDTH  message number to read
- loc_valid_i  in  1  addressed entry holds a message (valid cycle after loc_re_o)
- loc_start_i / loc_end_i  in  ADDR_WIDTH each  message window (valid cycle after loc_re_o)
- search_o  out  1  CAM search strobe
- find_tag_o  out  TAG_WIDTH  tag to search
- start_idx_o / end_idx_o  out  ADDR_WIDTH each  search window
- tag_match_i  in  1  CAM hit
- index_i  in  ADDR_WIDTH  matched CAM index
- val_oe_o  out  1  value RAM read enable
- val_addr_o  out  ADDR_WIDTH  value RAM address
- val_data_i  in  VALUE_WIDTH  value RAM data (valid cycle after val_oe_o)

## Operation
- FSM states: IDLE, LOC_RD, LOC_CAP, SEARCH, WAIT, VAL_RD, VAL_CAP, DONE.
- IDLE: if any req_i and !wr_busy_i, grant round-robin. Priority starts at last_grant+1 mod NUM_REQ. Latch the granted index, message number and tag. A message number ≥ NUM_MESSAGE → DONE with miss. Otherwise → LOC_RD.
- LOC_RD: loc_re_o=1, loc_msg_o=latched msg → LOC_CAP.
- LOC_CAP: register loc_start_i/loc_end_i. If loc_valid_i=0 → DONE (miss), else → SEARCH.
- SEARCH: search_o=1 one cycle. find_tag_o, start_idx_o and end_idx_o are driven from latches and held stable through WAIT → WAIT.
- WAIT: counter runs SEARCH_LAT cycles. Sample tag_match_i/index_i in the last WAIT cycle. Match → VAL_RD; no match → DONE (miss).
- VAL_RD: val_oe_o=1, val_addr_o=captured index → VAL_CAP.
- VAL_CAP: register val_data_i, set hit → DONE.
- DONE: ack_o[grant]=1 for one cycle, hit_o/value_o valid; update last_grant → IDLE.
- Requester must hold req_i and operands until its ack. A req dropped mid-query is ignored and the query still completes and acks. Req re-sampled in IDLE the cycle after DONE.
- Simultaneous requests are served strictly round-robin, with no starvation: worst-case wait is NUM_REQ−1 queries.
- wr_busy_i only gates grants. A query already granted completes regardless.
- Reset: state IDLE, last_grant=NUM_REQ−1 (req 0 highest first), all outputs 0, latches 0. Reset mid-query aborts with no ack.

## Timing
- Request sampled in IDLE at cycle 0.
- Hit: ack at cycle 6+SEARCH_LAT (8 at default).
- CAM miss: ack at cycle 4+SEARCH_LAT (6).
- Empty message: ack at cycle 3.
- Out-of-range msg: ack at cycle 1.
- busy_o=1 from cycle 1 through DONE inclusive.
- All strobes are registered and high for exactly one cycle. hit_o/value_o are valid only in the ack cycle and 0 otherwise.

## Structure
- fix_parser_pkg: state enum fix_query_state_t, default width constants (TAG_WIDTH, VALUE_WIDTH, ADDR_WIDTH).
- Sub-module rr_arbiter (parameter N): inputs req, last_grant, enable; outputs one-hot grant plus encoded index. Reused later for storage write/read sharing.

## Test plan
- Single query req0, msg 3 valid window 4..9, CAM matches index 6 at SEARCH_LAT=2 → ack_o=0001 at cycle 8, hit_o=1, value_o=RAM[6]; val_addr_o=6.
- Tag absent → ack at cycle 6, hit_o=0, value_o=0; val_oe_o never asserted.
- req_msg_i=12 → ack at cycle 1, hit_o=0, no loc_re_o; loc_valid_i=0 case → ack at cycle 3.
- All four requesters held from reset → grants 0,1,2,3,0 in order; with req0 re-asserted after ack, the next grant is still 1.
- wr_busy_i high with req pending → no loc_re_o until wr_busy_i falls. wr_busy_i rising mid-query → query still acks.
- rst asserted during WAIT → no ack, all outputs 0 next cycle; next query granted to req0 first.

Source files
------------

// File: rtl/fix_parser_pkg.sv
// Shared types and default widths for the FIX parser storage and query logic.
package fix_parser_pkg;

  localparam int DEF_TAG_WIDTH   = 32;
  localparam int DEF_VALUE_WIDTH = 256;
  localparam int DEF_ADDR_WIDTH  = 5;

  typedef enum logic [2:0] {
    QS_IDLE    = 3'd0,
    QS_LOC_RD  = 3'd1,
    QS_LOC_CAP = 3'd2,
    QS_SEARCH  = 3'd3,
    QS_WAIT    = 3'd4,
    QS_VAL_RD  = 3'd5,
    QS_VAL_CAP = 3'd6,
    QS_DONE    = 3'd7
  } fix_query_state_t;

  // Position of the off-th candidate after last in a ring of n requesters.
  function automatic int rr_pos(input int last, input int off, input int n);
    return (last + off) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the requester after last_grant has top priority.
module rr_arbiter
  import fix_parser_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (enable && !found && req[rr_pos(int'(last_grant), i, N)]) begin
        found     = 1'b1;
        grant[rr_pos(int'(last_grant), i, N)] = 1'b1;
        grant_idx = IW'(rr_pos(int'(last_grant), i, N));
      end
    end
  end

endmodule

// File: rtl/fix_query_sched.sv
// Shares the location-table / tag-CAM / value-RAM lookup path among host query requesters.
//   state    | meaning
//   IDLE     | wait for a request while no storage write is in progress, arbitrate
//   LOC_RD   | location-table read strobe for the latched message
//   LOC_CAP  | capture message window, empty entry finishes as miss
//   SEARCH   | CAM search strobe over the window
//   WAIT     | CAM latency countdown, sample match in the last cycle
//   VAL_RD   | value RAM read strobe at the matched index
//   VAL_CAP  | capture value, mark hit
//   DONE     | ack the granted requester with hit/value
module fix_query_sched
  import fix_parser_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int NUM_MESSAGE = 10,
  parameter int MSG_WIDTH   = 4,
  parameter int TAG_WIDTH   = DEF_TAG_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int VALUE_WIDTH = DEF_VALUE_WIDTH,
  parameter int SEARCH_LAT  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ*MSG_WIDTH-1:0]   req_msg_i,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]   req_tag_i,
  output logic [NUM_REQ-1:0]             ack_o,
  output logic                           hit_o,
  output logic [VALUE_WIDTH-1:0]         value_o,
  output logic                           busy_o,
  input  logic                           wr_busy_i,
  output logic                           loc_re_o,
  output logic [MSG_WIDTH-1:0]           loc_msg_o,
  input  logic                           loc_valid_i,
  input  logic [ADDR_WIDTH-1:0]          loc_start_i,
  input  logic [ADDR_WIDTH-1:0]          loc_end_i,
  output logic                           search_o,
  output logic [TAG_WIDTH-1:0]           find_tag_o,
  output logic [ADDR_WIDTH-1:0]          start_idx_o,
  output logic [ADDR_WIDTH-1:0]          end_idx_o,
  input  logic                           tag_match_i,
  input  logic [ADDR_WIDTH-1:0]          index_i,
  output logic                           val_oe_o,
  output logic [ADDR_WIDTH-1:0]          val_addr_o,
  input  logic [VALUE_WIDTH-1:0]         val_data_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(SEARCH_LAT + 1);

  fix_query_state_t       state;
  logic [IDX_W-1:0]       last_grant;
  logic [IDX_W-1:0]       grant_idx;
  logic [NUM_REQ-1:0]     grant_oh;
  logic [MSG_WIDTH-1:0]   msg_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic [ADDR_WIDTH-1:0]  start_q;
  logic [ADDR_WIDTH-1:0]  end_q;
  logic [ADDR_WIDTH-1:0]  idx_q;
  logic [CNT_W-1:0]       cnt_q;

  logic [NUM_REQ-1:0]     arb_grant;
  logic [IDX_W-1:0]       arb_idx;
  logic [MSG_WIDTH-1:0]   sel_msg;
  logic [TAG_WIDTH-1:0]   sel_tag;

  rr_arbiter #(.N(NUM_REQ), .IW(IDX_W)) u_arb (
    .req        (req_i),
    .last_grant (last_grant),
    .enable     ((state == QS_IDLE) && !wr_busy_i),
    .grant      (arb_grant),
    .grant_idx  (arb_idx)
  );

  assign sel_msg = req_msg_i[arb_idx*MSG_WIDTH +: MSG_WIDTH];
  assign sel_tag = req_tag_i[arb_idx*TAG_WIDTH +: TAG_WIDTH];

  // Lookup-side addresses come straight from the latches so they stay stable through WAIT.
  assign loc_msg_o   = msg_q;
  assign find_tag_o  = tag_q;
  assign start_idx_o = start_q;
  assign end_idx_o   = end_q;
  assign val_addr_o  = idx_q;
  assign busy_o      = (state != QS_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= QS_IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      grant_idx  <= '0;
      grant_oh   <= '0;
      msg_q      <= '0;
      tag_q      <= '0;
      start_q    <= '0;
      end_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      ack_o      <= '0;
      hit_o      <= 1'b0;
      value_o    <= '0;
      loc_re_o   <= 1'b0;
      search_o   <= 1'b0;
      val_oe_o   <= 1'b0;
    end else begin
      ack_o    <= '0;
      hit_o    <= 1'b0;
      value_o  <= '0;
      loc_re_o <= 1'b0;
      search_o <= 1'b0;
      val_oe_o <= 1'b0;
      case (state)
        QS_IDLE: begin
          if (|arb_grant) begin
            grant_oh  <= arb_grant;
            grant_idx <= arb_idx;
            msg_q     <= sel_msg;
            tag_q     <= sel_tag;
            if (int'(sel_msg) >= NUM_MESSAGE) begin
              state <= QS_DONE;
              ack_o <= arb_grant;
            end else begin
              state    <= QS_LOC_RD;
              loc_re_o <= 1'b1;
            end
          end
        end
        QS_LOC_RD: state <= QS_LOC_CAP;
        QS_LOC_CAP: begin
          start_q <= loc_start_i;
          end_q   <= loc_end_i;
          if (!loc_valid_i) begin
            state <= QS_DONE;
            ack_o <= grant_oh;
          end else begin
            state    <= QS_SEARCH;
            search_o <= 1'b1;
          end
        end
        QS_SEARCH: begin
          state <= QS_WAIT;
          cnt_q <= CNT_W'(SEARCH_LAT - 1);
        end
        QS_WAIT: begin
          if (cnt_q == '0) begin
            if (tag_match_i) begin
              idx_q    <= index_i;
              state    <= QS_VAL_RD;
              val_oe_o <= 1'b1;
            end else begin
              state <= QS_DONE;
              ack_o <= grant_oh;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        QS_VAL_RD: state <= QS_VAL_CAP;
        QS_VAL_CAP: begin
          state   <= QS_DONE;
          ack_o   <= grant_oh;
          hit_o   <= 1'b1;
          value_o <= val_data_i;
        end
        QS_DONE: begin
          last_grant <= grant_idx;
          state      <= QS_IDLE;
        end
        default: state <= QS_IDLE;
      endcase
    end
  end

endmodule
